carrier_event_gen: RTL
======================

Name: carrier_event_gen

Overview:
- Carrier counter that produces the raw carrier min/max event pulses for one PWM channel.
- Its event_out drives maskevent_input of the downstream event_counter; it is the transmitting end of that event path.
- Supports up, down and up-down carriers, with a shadowed period that takes effect only at the carrier minimum.
- Sits in each pwm8carr channel between the register interface and event_counter/comparators.

Parameters:
- CARR_W, default `CARRIER_WIDTH (16): carrier and period width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- pwm_onoff  input  _pwm_onoff  PWM_ON enables counting.
- countmode  input  _count_mode  NO_COUNT / COUNT_UP / COUNT_DOWN / COUNT_UPDOWN.
- maskmode  input  _mask_mode  NO_MASK / MASK_MIN / MASK_MAX / MASK_MINMAX; selects which events reach event_out.
- period_in  input  CARR_W  shadow period, sampled at min boundary.
- carrier_out  output  CARR_W  registered carrier value.
- dir_out  output  1  1 = counting up, 0 = counting down.
- min_event  output  1  registered single-cycle pulse when carrier_out == 0 while counting.
- max_event  output  1  registered single-cycle pulse when carrier_out == period_act while counting.
- event_out  output  1  maskmode-selected event, registered, aligned with min_event/max_event.

Behaviour:
- Reset values: carrier_out=0, dir_out=1, period_act=0, min_event=0, max_event=0, event_out=0.
- Off state (pwm_onoff==PWM_OFF):
  - carrier_out forced to 0 and dir_out forced to 1.
  - period_act <= period_in every cycle (transparent load).
  - No events.
- COUNT_UP:
  - carrier increments by 1; at period_act the next value is 0.
  - max_event is asserted in the cycle carrier_out==period_act.
  - min_event is asserted in the cycle carrier_out==0 after a wrap.
- COUNT_DOWN:
  - carrier decrements by 1; at 0 the next value is period_act.
  - min_event at 0, max_event at period_act after reload.
- COUNT_UPDOWN:
  - Counts up to period_act, then down to 0; each extreme lasts exactly one cycle with no dwell.
  - dir_out toggles in the same cycle the extreme is output.
  - Carrier period is 2*period_act cycles.
- NO_COUNT: carrier_out and dir_out held; no events; period_act held.
- Event timing:
  - Events are decoded from next-state and registered, so each pulse coincides with carrier_out showing the boundary value.
  - Latency from pwm_onoff rising to first carrier change: 1 cycle.
  - No min_event is emitted for the initial 0 after OFF->ON.
- Shadow period:
  - period_act <= period_in in the cycle the next carrier value is 0 (min boundary).
  - An OFF->ON transition also loads period_in.
  - Changing period_in mid-ramp never shortens the current ramp.
- Degenerate period (period_act==0): carrier held at 0; min_event, max_event and event_out held 0; period reload at the boundary still occurs each cycle.
- Mode changes:
  - countmode applies on the next clock.
  - Switching to COUNT_UP forces dir_out=1; switching to COUNT_DOWN forces dir_out=0.
  - Carrier continues from its current value.
- event_out mapping:
  - NO_MASK -> 0.
  - MASK_MIN -> min_event.
  - MASK_MAX -> max_event.
  - MASK_MINMAX -> min_event | max_event.
- Reset asserted mid-operation clears everything immediately; counting restarts from 0 on the first edge after reset release with pwm_onoff==PWM_ON.
- Arithmetic is unsigned CARR_W; no overflow is possible because the carrier never exceeds period_act.

Optional Feature:
- Macro: CARRIER_PHASE_EN.
- With the macro:
  - Ports phase_in (CARR_W) and phase_dir (1) are added.
  - On the OFF->ON transition, carrier_out loads min(phase_in, period_in) and dir_out loads phase_dir (UPDOWN only; other modes use their fixed direction).
  - This enables interleaved carriers.
- Without the macro: ports are absent and the carrier always starts at 0, counting up (or at period_in for COUNT_DOWN after the first step).

Decomposition:
- Shared package holds _pwm_onoff, _count_mode, _mask_mode enums and the `CARRIER_WIDTH / `EVTCOUNT_WIDTH defines; identical to those used by event_counter.
- One sub-module is natural: carrier_event_sel, a registered maskmode-to-event_out mux. The rest stays in one always_ff plus next-state always_comb.

Test Plan:
- COUNT_UP, period_in=4, MASK_MAX -> carrier 0,1,2,3,4,0,...; max_event and event_out high when carrier=4, every 5 cycles; min_event high at each wrap 0.
- COUNT_UPDOWN, period_in=3, MASK_MINMAX -> carrier 0,1,2,3,2,1,0,1...; event_out high at 3 and at 0 (every 3 cycles); dir_out falls when carrier=3.
- COUNT_UP, period_in changed 4->6 while carrier=2 -> ramp still peaks at 4; next ramp peaks at 6.
- pwm_onoff toggled OFF at carrier=3 -> carrier 0, dir_out=1, no events; ON again -> 1 after one cycle.
- reset asserted asynchronously mid-ramp (carrier=5) -> all outputs 0 / dir_out 1 without waiting for clk.
- With CARRIER_PHASE_EN, UPDOWN, period=8, phase_in=5, phase_dir=0 -> on enable carrier 5,4,3,2,1,0 with min_event at 0.

Source files
------------

// File: rtl/carrier_event_gen_pkg.sv
// Shared PWM enums and width defines, identical to those used by event_counter.
// Defines: CARRIER_WIDTH (carrier/period width) and EVTCOUNT_WIDTH.
`ifndef CARRIER_EVENT_GEN_DEFS
`define CARRIER_EVENT_GEN_DEFS
`define CARRIER_WIDTH 16
`define EVTCOUNT_WIDTH 16
`endif

package carrier_event_gen_pkg;

    typedef enum logic {
        PWM_OFF = 1'b0,
        PWM_ON  = 1'b1
    } _pwm_onoff;

    typedef enum logic [1:0] {
        NO_COUNT     = 2'd0,
        COUNT_UP     = 2'd1,
        COUNT_DOWN   = 2'd2,
        COUNT_UPDOWN = 2'd3
    } _count_mode;

    typedef enum logic [1:0] {
        NO_MASK     = 2'd0,
        MASK_MIN    = 2'd1,
        MASK_MAX    = 2'd2,
        MASK_MINMAX = 2'd3
    } _mask_mode;

endpackage

// File: rtl/carrier_event_gen_sel.sv
// Registered maskmode-to-event_out mux; fed with next-state event decodes so the
// output lines up with the registered min_event/max_event pulses.
module carrier_event_sel
    import carrier_event_gen_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  _mask_mode maskmode,
    input  logic      min_nx,
    input  logic      max_nx,
    output logic      event_out
);

    logic event_nx;

    always_comb begin
        event_nx = 1'b0;
        unique case (maskmode)
            NO_MASK:     event_nx = 1'b0;
            MASK_MIN:    event_nx = min_nx;
            MASK_MAX:    event_nx = max_nx;
            MASK_MINMAX: event_nx = min_nx | max_nx;
            default:     event_nx = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            event_out <= 1'b0;
        end else begin
            event_out <= event_nx;
        end
    end

endmodule

// File: rtl/carrier_event_gen.sv
// Carrier counter (up / down / up-down) with shadowed period and min/max event pulses.
// Optional macro CARRIER_PHASE_EN adds phase_in/phase_dir to start the carrier at a phase.
//
// dir_out | meaning
// 1       | ramp rising (also the idle/off value)
// 0       | ramp falling
module carrier_event_gen
    import carrier_event_gen_pkg::*;
#(
    parameter int CARR_W = `CARRIER_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
`ifdef CARRIER_PHASE_EN
    input  logic [CARR_W-1:0] phase_in,
    input  logic              phase_dir,
`endif
    input  _pwm_onoff         pwm_onoff,
    input  _count_mode        countmode,
    input  _mask_mode         maskmode,
    input  logic [CARR_W-1:0] period_in,
    output logic [CARR_W-1:0] carrier_out,
    output logic              dir_out,
    output logic              min_event,
    output logic              max_event,
    output logic              event_out
);

    localparam logic [CARR_W-1:0] ONE = CARR_W'(1);

    logic [CARR_W-1:0] period_act;
    logic [CARR_W-1:0] period_eff;
    logic [CARR_W-1:0] period_nx;
    logic [CARR_W-1:0] carrier_nx;
    logic              dir_nx;
    logic              min_nx;
    logic              max_nx;
    logic              was_on;
    logic              running;
    logic              first_on;
    logic              counting;

    always_comb begin
        running    = (pwm_onoff == PWM_ON);
        first_on   = running && !was_on;
        counting   = running && (countmode != NO_COUNT);
        // The enabling edge steps with the freshly sampled period, not the stale shadow.
        period_eff = first_on ? period_in : period_act;
        carrier_nx = carrier_out;
        dir_nx     = dir_out;
        period_nx  = period_act;
        min_nx     = 1'b0;
        max_nx     = 1'b0;

        if (!running) begin
            carrier_nx = '0;
            dir_nx     = 1'b1;
            period_nx  = period_in;
        end else begin
            if (first_on) begin
                period_nx = period_in;
            end
            if (counting) begin
                unique case (countmode)
                    COUNT_UP: begin
                        dir_nx     = 1'b1;
                        carrier_nx = (carrier_out >= period_eff) ? '0 : carrier_out + ONE;
                    end
                    COUNT_DOWN: begin
                        dir_nx     = 1'b0;
                        carrier_nx = (carrier_out == '0 || carrier_out > period_eff) ?
                                     period_eff : carrier_out - ONE;
                    end
                    default: begin
                        if (period_eff == '0) begin
                            carrier_nx = '0;
                        end else begin
                            if (dir_out) begin
                                if (carrier_out >= period_eff) begin
                                    carrier_nx = period_eff - ONE;
                                    dir_nx     = 1'b0;
                                end else begin
                                    carrier_nx = carrier_out + ONE;
                                    dir_nx     = 1'b1;
                                end
                            end else begin
                                if (carrier_out == '0) begin
                                    carrier_nx = ONE;
                                    dir_nx     = 1'b1;
                                end else begin
                                    carrier_nx = carrier_out - ONE;
                                    dir_nx     = 1'b0;
                                end
                            end
                            // Extremes flip direction in the same cycle they are shown.
                            if (carrier_nx == period_eff) begin
                                dir_nx = 1'b0;
                            end else if (carrier_nx == '0) begin
                                dir_nx = 1'b1;
                            end
                        end
                    end
                endcase

                if (period_eff != '0) begin
                    min_nx = (carrier_nx == '0);
                    max_nx = (carrier_nx == period_eff);
                end
                if (carrier_nx == '0) begin
                    period_nx = period_in;
                end
            end
`ifdef CARRIER_PHASE_EN
            if (first_on) begin
                carrier_nx = (phase_in < period_in) ? phase_in : period_in;
                if (countmode == COUNT_UPDOWN) begin
                    dir_nx = phase_dir;
                end else if (countmode == COUNT_DOWN) begin
                    dir_nx = 1'b0;
                end else if (countmode == COUNT_UP) begin
                    dir_nx = 1'b1;
                end
                min_nx = 1'b0;
                max_nx = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carrier_out <= '0;
            dir_out     <= 1'b1;
            period_act  <= '0;
            min_event   <= 1'b0;
            max_event   <= 1'b0;
            was_on      <= 1'b0;
        end else begin
            carrier_out <= carrier_nx;
            dir_out     <= dir_nx;
            period_act  <= period_nx;
            min_event   <= min_nx;
            max_event   <= max_nx;
            was_on      <= running;
        end
    end

    carrier_event_sel u_sel (
        .clk       (clk),
        .reset     (reset),
        .maskmode  (maskmode),
        .min_nx    (min_nx),
        .max_nx    (max_nx),
        .event_out (event_out)
    );

endmodule
